// File: rtl/slave_spi_modes.sv
// SPI slave with compile-time mode (CPOL/CPHA), word length and bit order.
// Every pin is synchronised into the Clock domain; SCK edges are detected from the synchronised copy.
`timescale 1ns/1ps
module slave_spi_modes #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CS_i,
    input  logic             SCK_i,
    input  logic             MOSI_i,
    output logic             MISO_o,
    output logic             MisoEn_o,
    input  logic [WIDTH-1:0] DataToSend_i,
    output logic [WIDTH-1:0] DataReceived_o,
    output logic             Done_o,
    output logic             Aborted_o,
    output logic             Busy_o
);
    localparam int unsigned CW       = $clog2(WIDTH + 1);
    localparam logic        SCK_IDLE = 1'(CPOL);

    typedef enum logic [1:0] {IDLE, ACTIVE, END} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_d, sck_d, mosi_d;
    logic [SYNC_STAGES:0]   arm_sr;
    logic [WIDTH-1:0]       tx_sh, rx_sh, rx_next;
    logic [CW-1:0]          cnt;
    logic                   cs_s, sck_s, armed;
    logic                   cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Synchronisers plus edge-detect registers; arm_sr blanks CS edges until the preset values have flushed out
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cs_sync   <= '1;
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            sck_d     <= SCK_IDLE;
            mosi_d    <= 1'b0;
            arm_sr    <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_i};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_i};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sck_d     <= sck_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
            arm_sr    <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign armed       = arm_sr[SYNC_STAGES];
    assign cs_fall     = armed & cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;
    assign lead_edge   = (sck_d == SCK_IDLE) && (sck_s != SCK_IDLE);
    assign trail_edge  = (sck_d != SCK_IDLE) && (sck_s == SCK_IDLE);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign rx_next     = (MSB_FIRST != 0) ? {rx_sh[WIDTH-2:0], mosi_d} : {mosi_d, rx_sh[WIDTH-1:1]};

    // Frame FSM with all outputs registered; CS rise takes priority over a coincident sampling edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            tx_sh          <= '0;
            rx_sh          <= '0;
            cnt            <= '0;
            MISO_o         <= 1'b0;
            MisoEn_o       <= 1'b0;
            Busy_o         <= 1'b0;
            Done_o         <= 1'b0;
            Aborted_o      <= 1'b0;
            DataReceived_o <= '0;
        end else begin
            Done_o    <= 1'b0;
            Aborted_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        Busy_o   <= 1'b1;
                        MisoEn_o <= 1'b1;
                        cnt      <= '0;
                        rx_sh    <= '0;
                        if (CPHA == 0) begin
                            MISO_o <= head_bit(DataToSend_i);
                            tx_sh  <= shift_out(DataToSend_i);
                        end else begin
                            MISO_o <= 1'b0;
                            tx_sh  <= DataToSend_i;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= END;
                        Busy_o    <= 1'b0;
                        MisoEn_o  <= 1'b0;
                        MISO_o    <= 1'b0;
                        Aborted_o <= (cnt != '0);
                        cnt       <= '0;
                        rx_sh     <= '0;
                    end else if (sample_edge) begin
                        rx_sh <= rx_next;
                        if (cnt == CW'(WIDTH - 1)) begin
                            cnt            <= '0;
                            DataReceived_o <= rx_next;
                            Done_o         <= 1'b1;
                            tx_sh          <= DataToSend_i;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (shift_edge) begin
                        MISO_o <= head_bit(tx_sh);
                        tx_sh  <= shift_out(tx_sh);
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_spi_modes.sv
// Directed bench for slave_spi_modes: three instances (mode 0, mode 3, LSB-first 16-bit) share one master model.
`timescale 1ns/1ps
module tb_slave_spi_modes;
    localparam int HALF = 7900;
    localparam int CLKP = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs = 1'b1, sck = 1'b0, mosi = 1'b0;
    int          sel = 0;
    logic [31:0] tx = '0;

    logic        cs0, sck0, cs1, sck1, cs2, sck2;
    logic        miso0, en0, done0, ab0, busy0;
    logic        miso1, en1, done1, ab1, busy1;
    logic        miso2, en2, done2, ab2, busy2;
    logic [7:0]  dr0, dr1;
    logic [15:0] dr2;
    logic        miso_s, en_s, done_s, ab_s, busy_s;
    logic [31:0] dr_s;

    int          n_checks = 0, n_fail = 0;
    int          done_total = 0, ab_total = 0;
    logic [31:0] hist [8];

    always #(CLKP/2) clk = ~clk;

    assign cs0  = (sel == 0) ? cs  : 1'b1;
    assign sck0 = (sel == 0) ? sck : 1'b0;
    assign cs1  = (sel == 1) ? cs  : 1'b1;
    assign sck1 = (sel == 1) ? sck : 1'b1;
    assign cs2  = (sel == 2) ? cs  : 1'b1;
    assign sck2 = (sel == 2) ? sck : 1'b0;

    slave_spi_modes #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
        .Clock(clk), .Reset(rst_n), .CS_i(cs0), .SCK_i(sck0), .MOSI_i(mosi),
        .MISO_o(miso0), .MisoEn_o(en0), .DataToSend_i(tx[7:0]), .DataReceived_o(dr0),
        .Done_o(done0), .Aborted_o(ab0), .Busy_o(busy0));

    slave_spi_modes #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .Clock(clk), .Reset(rst_n), .CS_i(cs1), .SCK_i(sck1), .MOSI_i(mosi),
        .MISO_o(miso1), .MisoEn_o(en1), .DataToSend_i(tx[7:0]), .DataReceived_o(dr1),
        .Done_o(done1), .Aborted_o(ab1), .Busy_o(busy1));

    slave_spi_modes #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(3)) u_lsb (
        .Clock(clk), .Reset(rst_n), .CS_i(cs2), .SCK_i(sck2), .MOSI_i(mosi),
        .MISO_o(miso2), .MisoEn_o(en2), .DataToSend_i(tx[15:0]), .DataReceived_o(dr2),
        .Done_o(done2), .Aborted_o(ab2), .Busy_o(busy2));

    always_comb begin
        case (sel)
            1: begin miso_s = miso1; en_s = en1; done_s = done1; ab_s = ab1; busy_s = busy1; dr_s = {24'h0, dr1}; end
            2: begin miso_s = miso2; en_s = en2; done_s = done2; ab_s = ab2; busy_s = busy2; dr_s = {16'h0, dr2}; end
            default: begin miso_s = miso0; en_s = en0; done_s = done0; ab_s = ab0; busy_s = busy0; dr_s = {24'h0, dr0}; end
        endcase
    end

    // Pulse monitor: logs every received word and counts abort pulses of the selected slave
    always @(negedge clk) begin
        if (done_s === 1'b1) begin
            hist[done_total % 8] = dr_s;
            done_total++;
        end
        if (ab_s === 1'b1) ab_total++;
    end

    task automatic run_bits(input int cpol, input int cpha, input int msb, input int width,
                            input int nbits, input logic [31:0] mo, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = (msb != 0) ? width - 1 - i : i;
            if (cpha == 0) begin
                mosi = mo[idx];
                #HALF; sck = (cpol == 0); mi[idx] = miso_s;
                #HALF; sck = (cpol != 0);
            end else begin
                sck = (cpol == 0); mosi = mo[idx];
                #HALF; sck = (cpol != 0); mi[idx] = miso_s;
                #HALF;
            end
        end
    endtask

    task automatic frame(input int cpol, input int cpha, input int msb, input int width,
                         input logic [31:0] mo, output logic [31:0] mi);
        cs = 1'b0;
        #HALF;
        run_bits(cpol, cpha, msb, width, width, mo, mi);
        #HALF;
        cs = 1'b1;
        #(20*CLKP);
    endtask

    task automatic test_reset();
        sel = 0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx = '0;
        #100; rst_n = 1'b0;
        #(3*CLKP + 400);
        n_checks++;
        if ({miso0, en0, done0, ab0, busy0} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outs: got %b expected 00000", {miso0, en0, done0, ab0, busy0});
        end
        n_checks++;
        if (dr0 !== 8'h00) begin n_fail++; $display("FAIL reset_dr: got %h expected 00", dr0); end
        n_checks++;
        if ({busy1, en1, miso1, busy2, en2, miso2} !== 6'b0) begin
            n_fail++; $display("FAIL reset_others: got %b expected 000000", {busy1, en1, miso1, busy2, en2, miso2});
        end
        rst_n = 1'b1;
        #(10*CLKP);
    endtask

    task automatic test_mode0();
        logic [31:0] mi;
        int d0, a0;
        sel = 0; tx = 32'hA5; d0 = done_total; a0 = ab_total;
        frame(0, 0, 1, 8, 32'hAA, mi);
        n_checks++;
        if (done_total - d0 !== 1) begin n_fail++; $display("FAIL mode0_done_count: got %0d expected 1", done_total - d0); end
        n_checks++;
        if (dr_s !== 32'hAA) begin n_fail++; $display("FAIL mode0_rx: got %h expected aa", dr_s); end
        n_checks++;
        if (mi !== 32'hA5) begin n_fail++; $display("FAIL mode0_miso: got %h expected a5", mi); end
        n_checks++;
        if (ab_total - a0 !== 0) begin n_fail++; $display("FAIL mode0_abort: got %0d expected 0", ab_total - a0); end
        n_checks++;
        if ({busy_s, en_s, miso_s} !== 3'b0) begin n_fail++; $display("FAIL mode0_idle_outs: got %b expected 000", {busy_s, en_s, miso_s}); end
    endtask

    task automatic test_cs_high();
        logic [31:0] mi;
        int d0;
        sel = 0; cs = 1'b1; d0 = done_total;
        for (int b = 0; b < 8; b++) begin
            run_bits(0, 0, 1, 8, 1, 32'hFF, mi);
            n_checks++;
            if ({miso_s, en_s} !== 2'b00) begin n_fail++; $display("FAIL cshigh_pins bit %0d: got %b expected 00", b, {miso_s, en_s}); end
        end
        #(20*CLKP);
        n_checks++;
        if (done_total - d0 !== 0) begin n_fail++; $display("FAIL cshigh_done: got %0d expected 0", done_total - d0); end
        n_checks++;
        if (dr_s !== 32'hAA) begin n_fail++; $display("FAIL cshigh_rx_hold: got %h expected aa", dr_s); end
    endtask

    task automatic test_abort();
        logic [31:0] mi;
        int d0, a0;
        sel = 0; tx = 32'h5A; d0 = done_total; a0 = ab_total;
        cs = 1'b0; #HALF;
        run_bits(0, 0, 1, 8, 4, 32'h55, mi);
        #HALF; cs = 1'b1; #(20*CLKP);
        n_checks++;
        if (ab_total - a0 !== 1) begin n_fail++; $display("FAIL abort_pulse: got %0d expected 1", ab_total - a0); end
        n_checks++;
        if (done_total - d0 !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_total - d0); end
        n_checks++;
        if (dr_s !== 32'hAA) begin n_fail++; $display("FAIL abort_rx_hold: got %h expected aa", dr_s); end
        tx = 32'hF0; d0 = done_total; a0 = ab_total;
        frame(0, 0, 1, 8, 32'h00, mi);
        n_checks++;
        if (dr_s !== 32'h00) begin n_fail++; $display("FAIL abort_next_rx: got %h expected 00", dr_s); end
        n_checks++;
        if (mi !== 32'hF0) begin n_fail++; $display("FAIL abort_next_miso: got %h expected f0", mi); end
        n_checks++;
        if ((done_total - d0 !== 1) || (ab_total - a0 !== 0)) begin
            n_fail++; $display("FAIL abort_next_pulses: got done %0d abort %0d expected 1 0", done_total - d0, ab_total - a0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m1, m2;
        int d0, a0;
        sel = 1; sck = 1'b1; tx = 32'h96; d0 = done_total; a0 = ab_total;
        #(10*CLKP);
        cs = 1'b0; #HALF;
        run_bits(1, 1, 1, 8, 8, 32'h3C, m1);
        run_bits(1, 1, 1, 8, 8, 32'hC3, m2);
        #HALF; cs = 1'b1; #(20*CLKP);
        n_checks++;
        if (done_total - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_total - d0); end
        n_checks++;
        if (hist[d0 % 8] !== 32'h3C) begin n_fail++; $display("FAIL b2b_word0: got %h expected 3c", hist[d0 % 8]); end
        n_checks++;
        if (hist[(d0 + 1) % 8] !== 32'hC3) begin n_fail++; $display("FAIL b2b_word1: got %h expected c3", hist[(d0 + 1) % 8]); end
        n_checks++;
        if ((m1 !== 32'h96) || (m2 !== 32'h96)) begin n_fail++; $display("FAIL b2b_miso: got %h %h expected 96 96", m1, m2); end
        n_checks++;
        if (ab_total - a0 !== 0) begin n_fail++; $display("FAIL b2b_abort: got %0d expected 0", ab_total - a0); end
        sel = 0; sck = 1'b0;
        #(10*CLKP);
    endtask

    task automatic test_lsb16();
        logic [31:0] mi;
        sel = 2; tx = 32'hBEEF;
        #(10*CLKP);
        frame(0, 0, 0, 16, 32'h1234, mi);
        n_checks++;
        if (dr_s !== 32'h1234) begin n_fail++; $display("FAIL lsb16_rx: got %h expected 1234", dr_s); end
        n_checks++;
        if (mi !== 32'hBEEF) begin n_fail++; $display("FAIL lsb16_miso: got %h expected beef", mi); end
        sel = 0;
        #(10*CLKP);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] mi;
        int d0, a0;
        sel = 0; tx = 32'h77; d0 = done_total; a0 = ab_total;
        cs = 1'b0; #HALF;
        run_bits(0, 0, 1, 8, 5, 32'hFF, mi);
        rst_n = 1'b0;
        #(3*CLKP);
        n_checks++;
        if ({miso_s, en_s, done_s, ab_s, busy_s, dr_s} !== 37'b0) begin
            n_fail++; $display("FAIL rstmid_outs: got %b %h expected 00000 0", {miso_s, en_s, done_s, ab_s, busy_s}, dr_s);
        end
        rst_n = 1'b1;
        #(20*CLKP);
        n_checks++;
        if ({busy_s, en_s} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_frame: got %b expected 00", {busy_s, en_s}); end
        n_checks++;
        if ((done_total - d0 !== 0) || (ab_total - a0 !== 0)) begin
            n_fail++; $display("FAIL rstmid_pulses: got done %0d abort %0d expected 0 0", done_total - d0, ab_total - a0);
        end
        cs = 1'b1; #(20*CLKP);
        tx = 32'h3C;
        frame(0, 0, 1, 8, 32'h81, mi);
        n_checks++;
        if (dr_s !== 32'h81) begin n_fail++; $display("FAIL rstmid_next_rx: got %h expected 81", dr_s); end
        n_checks++;
        if (mi !== 32'h3C) begin n_fail++; $display("FAIL rstmid_next_miso: got %h expected 3c", mi); end
        n_checks++;
        if ((done_total - d0 !== 1) || (ab_total - a0 !== 0)) begin
            n_fail++; $display("FAIL rstmid_next_pulses: got done %0d abort %0d expected 1 0", done_total - d0, ab_total - a0);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_cs_high();
        test_abort();
        test_back_to_back();
        test_lsb16();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
